mod_barrett_const_64b: RTL
==========================

MOD_BARRETT_CONST_64B -- requirements
Module: mod_barrett_const_64b

Interface
REQ-001 SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port iRstN, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port iClr, input, 1 bit: synchronous clear, returns the block to IDLE.
REQ-004 SHALL have port iStart, input, 1 bit: request to compute constants for iMod.
REQ-005 SHALL have port iMod, input, 64 bits: modulus M, sampled only when a start is accepted.
REQ-006 SHALL have port oReady, output, 1 bit: high in IDLE and DONE, when a start can be accepted.
REQ-007 SHALL have port oValid, output, 1 bit: high in DONE, meaning oU/oRem/oErr are valid.
REQ-008 SHALL have port oErr, output, 1 bit: the captured M was 0 or 1.
REQ-009 SHALL have port oU, output, 128 bits: Barrett constant floor(2^128 / M), in the same form as the multiplier's iU input.
REQ-010 SHALL have port oRem, output, 64 bits: 2^128 mod M.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 SHALL accept a start on a rising edge where iStart=1 and state is IDLE or DONE; the block SHALL capture iMod, clear oValid and oErr, and enter CALC (M>=2) or DONE with error (M<2).
REQ-013 SHALL use restoring division of dividend 2^128: on accept, remainder r=1, quotient q=0, bit counter=127.
REQ-014 SHALL do one iteration per CALC cycle: r'=(r<<1); if r'>=M then r=r'-M and q[i]=1, else r=r' and q[i]=0; i counts 127 down to 0.
REQ-015 SHALL hold r at 65 bits so the shifted remainder compares without overflow; q SHALL be 128 bits. Since M>=2, q SHALL fit without truncation.
REQ-016 SHALL enter DONE on the edge that completes iteration i=0; oValid SHALL rise exactly 128 edges after the accept edge (latency 128 cycles).
REQ-017 For M in {0,1}: SHALL enter DONE on the accept edge+1 with oErr=1, oValid=1, oU=0, oRem=0.
REQ-018 SHALL ignore iStart while in CALC; iMod changes after accept SHALL not affect the result.
REQ-019 SHALL hold oU/oRem/oValid/oErr stable in DONE until the next accepted start or iClr.
REQ-020 SHALL have iClr take priority over iStart in any state: next state IDLE, oValid=0, oErr=0, oU=0, oRem=0.
REQ-021 SHALL keep oU and oRem at 0 during CALC; they SHALL update only on entry to DONE.

Reset
REQ-022 On iRstN=0, asynchronously: state=IDLE, oReady=1, oValid=0, oErr=0, oU=0, oRem=0, internal r/q/counter/M=0.
REQ-023 Reset asserted mid-CALC SHALL abort immediately; no partial result SHALL be presented.
REQ-024 After release, the first start SHALL be acceptable on the first rising edge.

Structure
REQ-025 The shared package SHALL hold MOD_W=64, U_W=128, the state enum (IDLE/CALC/DONE) and the iteration count 128.
REQ-026 The per-iteration compare/subtract SHALL be one combinational sub-module, mod_div_step_64b (65-bit r in, M in, r out, quotient bit out).
REQ-027 The top level SHALL contain only the FSM, counter and registers; the target is 120-400 lines of RTL in total.

Verification
REQ-028 M=0xFFFF_FFFF_FFFF_FFFF, start -> after 128 cycles oValid=1, oU=0x1_0000_0000_0000_0001, oRem=1, oErr=0.
REQ-029 M=2 -> oU=2^127 (0x8000...0000), oRem=0; M=2^63 -> oU=2^65, oRem=0.
REQ-030 M=3 -> oU=0x5555_5555_5555_5555_5555_5555_5555_5555, oRem=1.
REQ-031 M=0 and M=1 -> next cycle oValid=1, oErr=1, oU=0, oRem=0.
REQ-032 Start M=3, pulse iStart with a different M at cycle 50, then iClr at cycle 60 -> the second start is ignored; IDLE after the iClr edge with outputs 0; iRstN low at cycle 30 of a new run -> outputs 0 immediately.
REQ-033 Random M (>=2) over 1000 runs -> oU*M+oRem == 2^128 and oRem<M; feeding oU/M into mod_multiplier_barrett_64b matches (a*b)%M.

Source files
------------

// File: rtl/mod_barrett_const_64b_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : mod_barrett_const_64b_pkg                                      |
// | Purpose  : Shared widths, iteration count and FSM state type for the     |
// |            Barrett constant generator (floor(2^128/M), 2^128 mod M).      |
// | Contents : MOD_W, U_W, R_W, ITER_COUNT, CNT_W, state_t                    |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
package mod_barrett_const_64b_pkg;

   localparam int MOD_W      = 64;          // modulus width
   localparam int U_W        = 128;         // Barrett constant width
   localparam int R_W        = MOD_W + 1;   // partial remainder width
   localparam int ITER_COUNT = 128;         // one quotient bit per iteration
   localparam int CNT_W      = 7;           // holds ITER_COUNT-1 .. 0

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : mod_barrett_const_64b_pkg
`default_nettype wire

// File: rtl/mod_div_step_64b.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : mod_div_step_64b                                               |
// | Purpose  : One restoring-division step: shift the partial remainder left |
// |            by one, subtract M when it fits, and emit the quotient bit.   |
// | Ports    : rem_in  [64:0] partial remainder (always < M)                  |
// |            mod     [63:0] divisor M                                       |
// |            rem_out [64:0] next partial remainder                          |
// |            q_bit          quotient bit for this step                      |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module mod_div_step_64b
   import mod_barrett_const_64b_pkg::*;
(
   input  logic [R_W-1:0]   rem_in,
   input  logic [MOD_W-1:0] mod,
   output logic [R_W-1:0]   rem_out,
   output logic             q_bit
);

   // Shift is carried one bit wider than the remainder so the compare is
   // exact for every input, even though rem_in < M keeps the top bit clear.
   logic [R_W:0]   shifted;
   logic [R_W-1:0] diff;
   logic           fits;

   always_comb begin
      shifted = {rem_in, 1'b0};
      fits    = (shifted >= {2'b00, mod});
      diff    = shifted[R_W-1:0] - {1'b0, mod};
      rem_out = fits ? diff : shifted[R_W-1:0];
      q_bit   = fits;
   end

endmodule : mod_div_step_64b
`default_nettype wire

// File: rtl/mod_barrett_const_64b.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : mod_barrett_const_64b                                          |
// | Purpose  : Computes the Barrett constant oU = floor(2^128 / M) and        |
// |            oRem = 2^128 mod M by bit-serial restoring division, one      |
// |            quotient bit per clock (128-cycle latency).                    |
// | Ports    : iClk    clock, rising edge                                     |
// |            iRstN   asynchronous active-low reset                          |
// |            iClr    synchronous clear back to IDLE (beats iStart)          |
// |            iStart  start request, honoured in IDLE or DONE                |
// |            iMod    modulus M, captured on an accepted start               |
// |            oReady  high in IDLE and DONE                                  |
// |            oValid  high in DONE, results valid                            |
// |            oErr    captured M was 0 or 1                                  |
// |            oU      floor(2^128 / M)                                       |
// |            oRem    2^128 mod M                                            |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module mod_barrett_const_64b
   import mod_barrett_const_64b_pkg::*;
(
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iClr,
   input  logic             iStart,
   input  logic [MOD_W-1:0] iMod,
   output logic             oReady,
   output logic             oValid,
   output logic             oErr,
   output logic [U_W-1:0]   oU,
   output logic [MOD_W-1:0] oRem
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

   state_t             state;
   state_t             state_next;
   logic [MOD_W-1:0]   mod_reg;
   logic [R_W-1:0]     rem_reg;
   logic [U_W-1:0]     quo_reg;
   logic [CNT_W-1:0]   cnt;

   logic [R_W-1:0]     rem_step;
   logic               q_bit;
   logic [U_W-1:0]     quo_step;
   logic               accept;
   logic               mod_small;
   logic               last_iter;

   mod_div_step_64b u_step (
      .rem_in  (rem_reg),
      .mod     (mod_reg),
      .rem_out (rem_step),
      .q_bit   (q_bit)
   );

   // Quotient bits arrive MSB first, so shifting in from the right places
   // bit i of the quotient at position i after the final step.
   assign quo_step  = {quo_reg[U_W-2:0], q_bit};
   assign oReady    = (state == ST_IDLE) || (state == ST_DONE);
   assign accept    = iStart && oReady;
   assign mod_small = (iMod[MOD_W-1:1] == '0);
   assign last_iter = (state == ST_CALC) && (cnt == '0);

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (iClr) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (iStart) begin
                  state_next = mod_small ? ST_DONE : ST_CALC;
               end
            end
            ST_CALC: begin
               if (cnt == '0) begin
                  state_next = ST_DONE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         mod_reg <= '0;
         rem_reg <= '0;
         quo_reg <= '0;
         cnt     <= '0;
         oValid  <= 1'b0;
         oErr    <= 1'b0;
         oU      <= '0;
         oRem    <= '0;
      end else if (iClr) begin
         mod_reg <= '0;
         rem_reg <= '0;
         quo_reg <= '0;
         cnt     <= '0;
         oValid  <= 1'b0;
         oErr    <= 1'b0;
         oU      <= '0;
         oRem    <= '0;
      end else if (accept) begin
         // Dividend 2^128: the leading 1 seeds the remainder and the 128
         // zero bits below it are shifted in by the iterations.
         mod_reg <= iMod;
         rem_reg <= R_W'(1);
         quo_reg <= '0;
         cnt     <= CNT_LAST;
         oValid  <= mod_small;
         oErr    <= mod_small;
         oU      <= '0;
         oRem    <= '0;
      end else if (state == ST_CALC) begin
         rem_reg <= rem_step;
         quo_reg <= quo_step;
         cnt     <= cnt - 1'b1;
         if (last_iter) begin
            oValid <= 1'b1;
            oU     <= quo_step;
            oRem   <= rem_step[MOD_W-1:0];
         end
      end
   end

endmodule : mod_barrett_const_64b
`default_nettype wire
